dac_sample_streamer: RTL and testbench
======================================

DAC_SAMPLE_STREAMER -- requirements
Module: dac_sample_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample-pair buffer depth (power of 2).
REQ-002 SHALL have parameter IDLE_CODE, default 10'h200, midscale offset-binary code driven when not streaming.
REQ-003 SHALL have port Bus2IP_Clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port Bus2IP_Reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port Wr_Valid  in  1  sample-pair write strobe from slave register decode.
REQ-006 SHALL have port Wr_Data  in  [0:31]  I sample = Wr_Data[6:15], Q sample = Wr_Data[22:31]; other bits ignored.
REQ-007 SHALL have port Wr_Ready  out  1  high when FIFO level < FIFO_DEPTH.
REQ-008 SHALL have port Ctrl_Enable  in  1  streaming enable.
REQ-009 SHALL have port Rate_Div  in  [0:15]  output phase period minus one, in Bus2IP_Clk cycles.
REQ-010 SHALL have port Underrun_Clr  in  1  single-cycle clear of Underrun.
REQ-011 SHALL have port Fifo_Level  out  [0:log2(FIFO_DEPTH)]  current occupancy, 0..FIFO_DEPTH.
REQ-012 SHALL have port Underrun  out  1  sticky underrun flag.
REQ-013 SHALL have port S_Data  out  [0:9]  registered DAC data bus.
REQ-014 SHALL have port S_DCLKIO  out  1  interleave select: 1 = I phase, 0 = Q phase.
REQ-015 SHALL have ports S_OpEnI, S_OpEnQ, S_PWRDN  out  1 each  channel enables and power-down.

Function
REQ-016 SHALL buffer pairs in a FIFO; push when Wr_Valid and Wr_Ready; Wr_Valid while full ignored, no state change.
REQ-017 SHALL implement FSM states IDLE and RUN.
REQ-018 IDLE->RUN when Ctrl_Enable=1 and Fifo_Level>=1; phase counter loaded 0, phase set to I.
REQ-019 In RUN, tick SHALL assert when phase counter=0; counter reloads Rate_Div on tick, else decrements.
REQ-020 On I-phase tick: pop one pair if FIFO non-empty into I/Q hold registers; S_Data<=I, S_DCLKIO<=1 one cycle after tick; phase->Q.
REQ-021 On Q-phase tick: S_Data<=held Q, S_DCLKIO<=0 one cycle after tick; phase->I.
REQ-022 Output pair rate SHALL be Bus2IP_Clk/(2*(Rate_Div+1)); Rate_Div=0 gives alternating I/Q every cycle.
REQ-023 Rate_Div changes SHALL take effect only at the next reload.
REQ-024 I-phase tick with FIFO empty: no pop, previous I/Q repeated, Underrun set same cycle.
REQ-025 Push and pop in same cycle SHALL leave Fifo_Level unchanged; push into empty FIFO on an I tick does not satisfy that tick (underrun).
REQ-026 Underrun set and Underrun_Clr in same cycle: set wins.
REQ-027 Ctrl_Enable=0 in RUN: remain RUN until next I-phase tick (current pair completes), then IDLE, no pop at that tick.
REQ-028 In IDLE: S_Data=IDLE_CODE, S_DCLKIO=0, S_OpEnI=S_OpEnQ=0, S_PWRDN=~Ctrl_Enable; in RUN: S_OpEnI=S_OpEnQ=1, S_PWRDN=0.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; Fifo_Level SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-030 Bus2IP_Reset=1 SHALL, at next edge, force IDLE, empty FIFO, counter=0, phase=I, Underrun=0, S_Data=IDLE_CODE, S_DCLKIO=0, S_OpEnI=S_OpEnQ=0, S_PWRDN=1, Wr_Ready=1, Fifo_Level=0.
REQ-031 Reset asserted mid-RUN SHALL discard buffered data and abort the pair in progress; no push accepted while reset high.

Verification
REQ-032 Rate_Div=3, push 0x0155_02AA, enable -> S_Data 0x155/DCLKIO=1 4 cycles, then 0x2AA/DCLKIO=0 4 cycles, Underrun set at next I tick.
REQ-033 Push 17 pairs while disabled, FIFO_DEPTH=16 -> Wr_Ready=0 after 16th, 17th dropped, Fifo_Level=16.
REQ-034 Rate_Div=0, 4 pairs queued, enable -> 8 consecutive cycles alternating I,Q,... in push order, then repeat of last pair with Underrun=1.
REQ-035 Deassert Ctrl_Enable during Q phase with 3 pairs queued -> Q held to phase end, IDLE, S_Data=0x200, Fifo_Level=3.
REQ-036 Assert Bus2IP_Reset mid-RUN with 5 pairs queued -> next cycle all outputs at REQ-030 values, Fifo_Level=0.
REQ-037 Underrun_Clr pulsed coincident with underrun tick -> Underrun stays 1; pulsed alone next cycle -> 0.

Source files
------------

// File: rtl/dac_sample_streamer.sv
// dac_sample_streamer: buffers I/Q sample pairs written over the slave bus and
// streams them to an interleaved 10-bit DAC port at a programmable phase rate.
module dac_sample_streamer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [9:0]  IDLE_CODE  = 10'h200
) (
  input  logic                          Bus2IP_Clk,
  input  logic                          Bus2IP_Reset,
  input  logic                          Wr_Valid,
  input  logic [0:31]                   Wr_Data,
  output logic                          Wr_Ready,
  input  logic                          Ctrl_Enable,
  input  logic [0:15]                   Rate_Div,
  input  logic                          Underrun_Clr,
  output logic [0:$clog2(FIFO_DEPTH)]   Fifo_Level,
  output logic                          Underrun,
  output logic [0:9]                    S_Data,
  output logic                          S_DCLKIO,
  output logic                          S_OpEnI,
  output logic                          S_OpEnQ,
  output logic                          S_PWRDN
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned SW = 10;
  localparam int unsigned CW = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_i_q, phase_i_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [SW-1:0]   hold_i_q, hold_i_d;
  logic [SW-1:0]   hold_q_q, hold_q_d;
  logic [SW-1:0]   s_data_q, s_data_d;
  logic            dclk_q, dclk_d;
  logic            open_q, open_d;
  logic            pwrdn_q, pwrdn_d;
  logic            underrun_q, underrun_d;
  logic            wr_ready_q, wr_ready_d;

  logic [2*SW-1:0] mem_q [FIFO_DEPTH];
  logic [2*SW-1:0] wr_pair;
  logic [2*SW-1:0] rd_pair;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            underrun_set;
  logic            unused_wr_bits;

  // Upper I sample and lower Q sample; remaining write bits carry nothing.
  assign wr_pair        = {Wr_Data[6:15], Wr_Data[22:31]};
  assign unused_wr_bits = ^{Wr_Data[0:5], Wr_Data[16:21]};
  assign rd_pair        = mem_q[rd_ptr_q];
  assign fifo_empty     = (level_q == '0);
  assign push           = Wr_Valid && wr_ready_q && !Bus2IP_Reset;

  // Sample-pair storage; pointers wrap naturally modulo the power-of-2 depth.
  always_ff @(posedge Bus2IP_Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_pair;
    end
  end

  // Next-state: IDLE/RUN sequencing, phase ticks, FIFO bookkeeping, outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_i_d    = phase_i_q;
    hold_i_d     = hold_i_q;
    hold_q_d     = hold_q_q;
    s_data_d     = s_data_q;
    dclk_d       = dclk_q;
    pop          = 1'b0;
    underrun_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Ctrl_Enable && !fifo_empty) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          phase_i_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          cnt_d = Rate_Div;
          if (phase_i_q) begin
            // A disable only lands on a pair boundary, and then nothing is popped.
            if (!Ctrl_Enable) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              if (!fifo_empty) begin
                pop      = 1'b1;
                hold_i_d = rd_pair[2*SW-1:SW];
                hold_q_d = rd_pair[SW-1:0];
              end else begin
                underrun_set = 1'b1;
              end
              s_data_d  = fifo_empty ? hold_i_q : rd_pair[2*SW-1:SW];
              dclk_d    = 1'b1;
              phase_i_d = 1'b0;
            end
          end else begin
            s_data_d  = hold_q_q;
            dclk_d    = 1'b0;
            phase_i_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      s_data_d = IDLE_CODE;
      dclk_d   = 1'b0;
      open_d   = 1'b0;
      pwrdn_d  = !Ctrl_Enable;
    end else begin
      open_d   = 1'b1;
      pwrdn_d  = 1'b0;
    end

    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    wr_ready_d = (level_d != LW'(FIFO_DEPTH));

    // A coincident set beats the clear.
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (Underrun_Clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      phase_i_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hold_i_q   <= IDLE_CODE;
      hold_q_q   <= IDLE_CODE;
      s_data_q   <= IDLE_CODE;
      dclk_q     <= 1'b0;
      open_q     <= 1'b0;
      pwrdn_q    <= 1'b1;
      underrun_q <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_i_q  <= phase_i_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hold_i_q   <= hold_i_d;
      hold_q_q   <= hold_q_d;
      s_data_q   <= s_data_d;
      dclk_q     <= dclk_d;
      open_q     <= open_d;
      pwrdn_q    <= pwrdn_d;
      underrun_q <= underrun_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign Wr_Ready   = wr_ready_q;
  assign Fifo_Level = level_q;
  assign Underrun   = underrun_q;
  assign S_Data     = s_data_q;
  assign S_DCLKIO   = dclk_q;
  assign S_OpEnI    = open_q;
  assign S_OpEnQ    = open_q;
  assign S_PWRDN    = pwrdn_q;

endmodule

// File: tb/tb_dac_sample_streamer.sv
// tb_dac_sample_streamer: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based model scheduled on absolute tick times.
module tb_dac_sample_streamer;

  localparam int unsigned DEPTH = 16;
  localparam logic [9:0]  IDLE  = 10'h200;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        en;
  logic [15:0] rdiv;
  logic        clr;
  logic        wr_ready;
  logic [4:0]  level;
  logic        underrun;
  logic [9:0]  s_data;
  logic        dclk;
  logic        open_i;
  logic        open_q;
  logic        pwrdn;

  always #5 clk = ~clk;

  dac_sample_streamer #(.FIFO_DEPTH(DEPTH), .IDLE_CODE(IDLE)) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Reset (rst),
    .Wr_Valid     (wr_valid),
    .Wr_Data      (wr_data),
    .Wr_Ready     (wr_ready),
    .Ctrl_Enable  (en),
    .Rate_Div     (rdiv),
    .Underrun_Clr (clr),
    .Fifo_Level   (level),
    .Underrun     (underrun),
    .S_Data       (s_data),
    .S_DCLKIO     (dclk),
    .S_OpEnI      (open_i),
    .S_OpEnQ      (open_q),
    .S_PWRDN      (pwrdn)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pair queue, absolute edge index of the next tick.
  logic [19:0] mq[$];
  bit          m_run;
  bit          m_phase_i;
  bit          m_underrun;
  longint      cyc;
  longint      next_tick;
  logic [19:0] m_hold;
  logic [9:0]  m_sdata;
  bit          m_dclk;
  bit          m_open;
  bit          m_pwrdn;

  function automatic logic [19:0] pair_of(input logic [31:0] d);
    return {d[25:16], d[9:0]};
  endfunction

  task automatic model_step();
    bit push_ok;
    bit set_ur;
    cyc++;
    if (rst) begin
      mq.delete();
      m_run = 0; m_phase_i = 1; m_underrun = 0;
      m_hold = {IDLE, IDLE}; m_sdata = IDLE; m_dclk = 0;
      m_open = 0; m_pwrdn = 1;
      return;
    end
    push_ok = wr_valid && (mq.size() < DEPTH);
    set_ur  = 0;
    if (!m_run) begin
      if (en && mq.size() > 0) begin
        m_run = 1; m_phase_i = 1; next_tick = cyc + 1;
      end
    end else if (cyc == next_tick) begin
      next_tick = cyc + longint'(rdiv) + 1;
      if (m_phase_i) begin
        if (!en) begin
          m_run = 0;
        end else begin
          if (mq.size() > 0) m_hold = mq.pop_front();
          else set_ur = 1;
          m_sdata = m_hold[19:10]; m_dclk = 1; m_phase_i = 0;
        end
      end else begin
        m_sdata = m_hold[9:0]; m_dclk = 0; m_phase_i = 1;
      end
    end
    if (push_ok) mq.push_back(pair_of(wr_data));
    m_underrun = set_ur ? 1'b1 : (clr ? 1'b0 : m_underrun);
    if (!m_run) begin
      m_sdata = IDLE; m_dclk = 0; m_open = 0; m_pwrdn = !en;
    end else begin
      m_open = 1; m_pwrdn = 0;
    end
  endtask

  task automatic compare_all();
    check("s_data",   32'(s_data),   32'(m_sdata));
    check("dclkio",   32'(dclk),     32'(m_dclk));
    check("underrun", 32'(underrun), 32'(m_underrun));
    check("level",    32'(level),    32'(mq.size()));
    check("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
    check("en_pwrdn", 32'({open_i, open_q, pwrdn}), 32'({m_open, m_open, m_pwrdn}));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  logic [31:0] pd[4];

  initial begin
    rst = 1; wr_valid = 0; wr_data = '0; en = 0; rdiv = '0; clr = 0; cyc = 0;
    next_tick = 0;

    // Reset values
    cycle(); cycle();
    rst = 0;
    check("rst_sdata", 32'(s_data), 32'h200);
    check("rst_pwrdn", 32'(pwrdn), 32'd1);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);

    // Single pair at Rate_Div=3, then underrun and set-beats-clear
    rdiv = 16'd3; wr_valid = 1; wr_data = 32'h0155_02AA;
    cycle();
    wr_valid = 0; en = 1;
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("r32_i_data", 32'(s_data), 32'h155);
      check("r32_i_dclk", 32'(dclk), 32'd1);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      check("r32_q_data", 32'(s_data), 32'h2AA);
      check("r32_q_dclk", 32'(dclk), 32'd0);
      if (i == 3) clr = 1;
      cycle();
    end
    check("r37_set_wins", 32'(underrun), 32'd1);
    check("r32_repeat_i", 32'(s_data), 32'h155);
    cycle();
    clr = 0;
    check("r37_clear", 32'(underrun), 32'd0);
    en = 0;
    repeat (12) cycle();
    check("disable_idle", 32'(s_data), 32'h200);

    // Fill beyond depth while disabled
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1; wr_data = $urandom;
      cycle();
      if (i == 15) begin
        check("r33_ready_full", 32'(wr_ready), 32'd0);
        check("r33_level_16", 32'(level), 32'd16);
      end
    end
    wr_valid = 0;
    check("r33_drop_17th", 32'(level), 32'd16);

    // Four pairs at Rate_Div=0
    rst = 1; cycle(); rst = 0;
    check("r34_empty", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pd[i] = $urandom; wr_valid = 1; wr_data = pd[i];
      cycle();
    end
    wr_valid = 0; rdiv = 16'd0; en = 1;
    cycle();
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("r34_data", 32'(s_data), (k % 2 == 0) ? 32'(pd[k/2][25:16]) : 32'(pd[k/2][9:0]));
      check("r34_dclk", 32'(dclk), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    check("r34_no_ur_yet", 32'(underrun), 32'd0);
    cycle();
    check("r34_repeat", 32'(s_data), 32'(pd[3][25:16]));
    check("r34_underrun", 32'(underrun), 32'd1);
    en = 0;
    repeat (4) cycle();

    // Disable during Q phase with 3 pairs left
    clr = 1; cycle(); clr = 0;
    for (int i = 0; i < 4; i++) begin
      pd[i] = $urandom; wr_valid = 1; wr_data = pd[i];
      cycle();
    end
    wr_valid = 0; rdiv = 16'd2; en = 1;
    cycle();
    cycle();
    repeat (3) cycle();
    check("r35_in_q", 32'(dclk), 32'd0);
    en = 0;
    repeat (2) begin
      cycle();
      check("r35_q_held", 32'(s_data), 32'(pd[0][9:0]));
    end
    cycle();
    check("r35_idle_code", 32'(s_data), 32'h200);
    check("r35_level", 32'(level), 32'd3);
    check("r35_open", 32'(open_i), 32'd0);

    // Reset mid-RUN with 5 pairs queued
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_data = $urandom;
      cycle();
    end
    wr_valid = 0; en = 1; rdiv = 16'd1;
    cycle();
    cycle();
    check("r36_five", 32'(level), 32'd5);
    rst = 1; wr_valid = 1; wr_data = $urandom;
    cycle();
    check("r36_sdata", 32'(s_data), 32'h200);
    check("r36_dclk", 32'(dclk), 32'd0);
    check("r36_open", 32'({open_i, open_q}), 32'd0);
    check("r36_pwrdn", 32'(pwrdn), 32'd1);
    check("r36_ready", 32'(wr_ready), 32'd1);
    check("r36_level", 32'(level), 32'd0);
    rst = 0; wr_valid = 0; en = 0;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      wr_valid = ((n / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      wr_data  = $urandom;
      if ($urandom_range(0, 49) == 0) en = !en;
      if ($urandom_range(0, 79) == 0) rdiv = 16'($urandom_range(0, 4));
      clr      = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
